vga_rect_fill: RTL and testbench
================================

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter AVN_AW, default 18, meaning Avalon address width.
REQ-002 SHALL have parameter AVN_DW, default 16, meaning Avalon data width.
REQ-003 SHALL have parameter RGB_SIZE, default 12, meaning pixel colour width, with RGB_SIZE <= AVN_DW.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, ports named sys_clk and sys_rst.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  fill command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x0  in  `H_SIZE  left column, inclusive.
- cmd_x1  in  `H_SIZE  right column, inclusive.
- cmd_y0  in  `V_SIZE  top row, inclusive.
- cmd_y1  in  `V_SIZE  bottom row, inclusive.
- cmd_rgb  in  RGB_SIZE  fill colour.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when a command completes.
- src_avn_write  out  1  Avalon write request toward the frame buffer source port.
- src_avn_read  out  1  tied to 0.
- src_avn_address  out  AVN_AW  pixel word address.
- src_avn_writedata  out  AVN_DW  pixel data.
- src_avn_waitrequest  in  1  frame buffer stall.

Function
REQ-006 SHALL implement FSM states IDLE, CLIP, WRITE, DONE.
REQ-007 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready and its fields are registered.
REQ-008 SHALL ignore cmd_valid in all states other than IDLE.
REQ-009 SHALL, in CLIP (1 cycle after accept):
- clamp x1 to `H_DISPLAY-1 and y1 to `V_DISPLAY-1.
- go to DONE if x0 > x1, y0 > y1, x0 >= `H_DISPLAY or y0 >= `V_DISPLAY (zero writes).
- otherwise load x = x0, y = y0 and go to WRITE.
REQ-010 SHALL, in WRITE, assert src_avn_write with:
- src_avn_address = (y*`H_DISPLAY + x), computed at full width and truncated to AVN_AW.
- src_avn_writedata = cmd_rgb zero-extended to AVN_DW.
REQ-011 SHALL hold address, data and write stable while src_avn_waitrequest = 1.
REQ-012 SHALL count a pixel written only on src_avn_write & ~src_avn_waitrequest, giving one pixel per cycle with no stall.
REQ-013 SHALL advance after each written pixel as follows:
- if x != x1: x+1.
- else if y != y1: x = x0, y+1.
- else: go to DONE.
REQ-014 SHALL issue exactly (x1-x0+1)*(y1-y0+1) writes using the clipped bounds, in raster order.
REQ-015 SHALL, in DONE, pulse done high for one cycle and return to IDLE, so cmd_ready is high on the following cycle.
REQ-016 SHALL drive busy = 1 in CLIP, WRITE and DONE.
REQ-017 SHALL deassert src_avn_write in every state other than WRITE.

Reset
REQ-018 SHALL, on sys_rst assertion (asynchronous), immediately enter IDLE with outputs cmd_ready=1, busy=0, done=0, src_avn_write=0, src_avn_address=0, src_avn_writedata=0.
REQ-019 SHALL abandon any in-progress fill on reset, leave pixels already written unchanged and not resume after reset.

Structure
REQ-020 SHALL take `H_SIZE, `V_SIZE, `H_DISPLAY and `V_DISPLAY from the shared vga.svh; the FSM state enum SHALL be a typedef in the shared package.
REQ-021 SHALL be a single module with no sub-modules; the address multiply SHALL be a constant multiply left to synthesis.

Verification (640x480 timing)
REQ-022 SHALL cover: (2,3)-(4,3), rgb 0xABC, waitrequest=0 -> writes to addresses 1922, 1923, 1924 with data 0x0ABC on consecutive cycles; done one cycle after the last write.
REQ-023 SHALL cover: same command with waitrequest high for 3 cycles on the 2nd write -> address 1923 and data held for 4 cycles; exactly 3 writes total.
REQ-024 SHALL cover: (630,100)-(700,105) -> clipped to x1=639; 60 writes; first address 64630, last address 67839.
REQ-025 SHALL cover: x0=10, x1=5 -> zero writes; done pulses 2 cycles after accept; cmd_ready high again on the 3rd cycle after accept.
REQ-026 SHALL cover: sys_rst asserted after 5 of 20 writes -> src_avn_write low in the same cycle, busy=0; a new command after release fills correctly.
REQ-027 SHALL cover: cmd_valid pulsed during a fill -> ignored; the write count equals the first command only.

Source files
------------

// File: rtl/vga_rect_fill_pkg.sv
// Shared types and geometry constants for the rectangle fill engine.
`include "vga.svh"

package vga_rect_fill_pkg;

    localparam int unsigned H_W    = `H_SIZE;
    localparam int unsigned V_W    = `V_SIZE;
    localparam int unsigned H_DISP = `H_DISPLAY;
    localparam int unsigned V_DISP = `V_DISPLAY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLIP  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/vga.svh
// Shared VGA geometry for the 640x480 mode: counter widths and visible extents.
`ifndef VGA_SVH
`define VGA_SVH

`define H_SIZE    11
`define V_SIZE    10
`define H_DISPLAY 640
`define V_DISPLAY 480

`endif

// File: rtl/vga_rect_fill.sv
// Fills a clipped rectangle of the frame buffer with one colour, one Avalon
// write per pixel in raster order.
`include "vga.svh"

module vga_rect_fill
    import vga_rect_fill_pkg::*;
#(
    parameter int unsigned AVN_AW   = 18,
    parameter int unsigned AVN_DW   = 16,
    parameter int unsigned RGB_SIZE = 12
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [`H_SIZE-1:0]   cmd_x0,
    input  logic [`H_SIZE-1:0]   cmd_x1,
    input  logic [`V_SIZE-1:0]   cmd_y0,
    input  logic [`V_SIZE-1:0]   cmd_y1,
    input  logic [RGB_SIZE-1:0]  cmd_rgb,
    output logic                 busy,
    output logic                 done,
    output logic                 src_avn_write,
    output logic                 src_avn_read,
    output logic [AVN_AW-1:0]    src_avn_address,
    output logic [AVN_DW-1:0]    src_avn_writedata,
    input  logic                 src_avn_waitrequest
);

    localparam int unsigned PW = H_W + V_W + 1;

    fill_state_e         state_q, state_d;
    logic [H_W-1:0]      x0_q, x0_d, x1_q, x1_d, x_q, x_d;
    logic [V_W-1:0]      y0_q, y0_d, y1_q, y1_d, y_q, y_d;
    logic [RGB_SIZE-1:0] rgb_q, rgb_d;

    logic [H_W-1:0]      x1_clip;
    logic [V_W-1:0]      y1_clip;
    logic                empty;
    logic [PW-1:0]       addr_full;

    always_comb begin
        x1_clip = (x1_q > H_W'(H_DISP - 1)) ? H_W'(H_DISP - 1) : x1_q;
        y1_clip = (y1_q > V_W'(V_DISP - 1)) ? V_W'(V_DISP - 1) : y1_q;
        empty   = (x0_q > x1_clip) || (y0_q > y1_clip) ||
                  (x0_q >= H_W'(H_DISP)) || (y0_q >= V_W'(V_DISP));
    end

    // Address is a pure function of the current pixel, so it holds by itself during a stall.
    assign addr_full         = PW'(y_q) * PW'(H_DISP) + PW'(x_q);
    assign src_avn_address   = AVN_AW'(addr_full);
    assign src_avn_writedata = AVN_DW'(rgb_q);
    assign src_avn_read      = 1'b0;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            x_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x_q     <= x_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        x0_d          = x0_q;
        x1_d          = x1_q;
        x_d           = x_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        y_d           = y_q;
        rgb_d         = rgb_q;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        src_avn_write = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    x1_d    = cmd_x1;
                    y0_d    = cmd_y0;
                    y1_d    = cmd_y1;
                    rgb_d   = cmd_rgb;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                x1_d = x1_clip;
                y1_d = y1_clip;
                if (empty) begin
                    state_d = DONE;
                end else begin
                    x_d     = x0_q;
                    y_d     = y0_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                src_avn_write = 1'b1;
                if (!src_avn_waitrequest) begin
                    if (x_q != x1_q) begin
                        x_d = x_q + H_W'(1);
                    end else if (y_q != y1_q) begin
                        x_d = x0_q;
                        y_d = y_q + V_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench: raster-order write model with directed and random rectangles.
module tb_vga_rect_fill;
    import vga_rect_fill_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RW = 12;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [H_W-1:0]    cmd_x0 = '0;
    logic [H_W-1:0]    cmd_x1 = '0;
    logic [V_W-1:0]    cmd_y0 = '0;
    logic [V_W-1:0]    cmd_y1 = '0;
    logic [RW-1:0]     cmd_rgb = '0;
    logic              busy;
    logic              done;
    logic              src_avn_write;
    logic              src_avn_read;
    logic [AW-1:0]     src_avn_address;
    logic [DW-1:0]     src_avn_writedata;
    logic              src_avn_waitrequest = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   wr_mode = 1'b0;
    bit   wr_force = 1'b0;

    wr_t  exp_q[$];
    wr_t  log_q[$];
    int   done_cnt = 0;
    int   exp_done = 0;
    int   done_cyc = 0;
    int   acc_cyc = 0;
    int   watch_addr = -1;
    int   watch_cnt = 0;
    bit   prev_stall = 1'b0;
    int   prev_addr = 0;
    int   prev_data = 0;

    vga_rect_fill #(
        .AVN_AW  (AW),
        .AVN_DW  (DW),
        .RGB_SIZE(RW)
    ) dut (
        .sys_clk            (clk),
        .sys_rst            (sys_rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_x0             (cmd_x0),
        .cmd_x1             (cmd_x1),
        .cmd_y0             (cmd_y0),
        .cmd_y1             (cmd_y1),
        .cmd_rgb            (cmd_rgb),
        .busy               (busy),
        .done               (done),
        .src_avn_write      (src_avn_write),
        .src_avn_read       (src_avn_read),
        .src_avn_address    (src_avn_address),
        .src_avn_writedata  (src_avn_writedata),
        .src_avn_waitrequest(src_avn_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        src_avn_waitrequest = wr_mode ? ($urandom_range(0, 3) == 0) : wr_force;
    end

    function automatic void chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Every pixel of the clipped rectangle, row by row, left to right.
    function automatic void push_model(input int x0, input int x1, input int y0, input int y1, input int rgb);
        int xe = (x1 > 639) ? 639 : x1;
        int ye = (y1 > 479) ? 479 : y1;
        wr_t w;
        if (x0 > xe || y0 > ye || x0 >= 640 || y0 >= 480) return;
        for (int y = y0; y <= ye; y++) begin
            for (int x = x0; x <= xe; x++) begin
                w.addr = (y * 640 + x) % (1 << AW);
                w.data = rgb % (1 << RW);
                w.cyc  = 0;
                exp_q.push_back(w);
            end
        end
    endfunction

    task automatic send_cmd(input int x0, input int x1, input int y0, input int y1, input int rgb);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk(cmd_ready == 1'b1, "ready_before_cmd", cmd_ready, 1);
        cmd_x0    = H_W'(x0);
        cmd_x1    = H_W'(x1);
        cmd_y0    = V_W'(y0);
        cmd_y1    = V_W'(y1);
        cmd_rgb   = RW'(rgb);
        cmd_valid = 1'b1;
        acc_cyc   = cyc;
        push_model(x0, x1, y0, y1, rgb);
        exp_done++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_dones(input int budget);
        int n = 0;
        while (done_cnt < exp_done && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(done_cnt == exp_done, "done_timeout", done_cnt, exp_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(cmd_ready == 1'b1, {tag, "_ready"}, cmd_ready, 1);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(done == 1'b0, {tag, "_done"}, done, 0);
        chk(src_avn_write == 1'b0, {tag, "_write"}, src_avn_write, 0);
        chk(src_avn_address == '0, {tag, "_addr"}, src_avn_address, 0);
        chk(src_avn_writedata == '0, {tag, "_data"}, src_avn_writedata, 0);
    endtask

    initial begin
        int x0, x1, y0, y1, n;

        fork
            forever begin
                @(negedge clk);
                if (!sys_rst) begin
                    chk(cmd_ready == !busy, "ready_vs_busy", cmd_ready, !busy);
                    chk(src_avn_read == 1'b0, "read_low", src_avn_read, 0);
                    if (prev_stall) begin
                        chk(src_avn_write && int'(src_avn_address) == prev_addr &&
                            int'(src_avn_writedata) == prev_data,
                            "stall_hold_addr", src_avn_address, prev_addr);
                    end
                    if (src_avn_write) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_write", src_avn_address, -1);
                        end else begin
                            chk(int'(src_avn_address) == exp_q[0].addr, "write_addr",
                                src_avn_address, exp_q[0].addr);
                            chk(int'(src_avn_writedata) == exp_q[0].data, "write_data",
                                src_avn_writedata, exp_q[0].data);
                        end
                        if (int'(src_avn_address) == watch_addr) watch_cnt++;
                        if (!src_avn_waitrequest) begin
                            wr_t w;
                            w.addr = int'(src_avn_address);
                            w.data = int'(src_avn_writedata);
                            w.cyc  = cyc;
                            log_q.push_back(w);
                            if (exp_q.size() > 0) void'(exp_q.pop_front());
                        end
                    end
                    if (done) begin
                        done_cnt++;
                        done_cyc = cyc;
                        chk(exp_q.size() == 0, "done_with_pending", exp_q.size(), 0);
                    end
                    prev_stall = src_avn_write && src_avn_waitrequest;
                    prev_addr  = int'(src_avn_address);
                    prev_data  = int'(src_avn_writedata);
                end else begin
                    prev_stall = 1'b0;
                end
            end
        join_none

        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        #1 sys_rst = 1'b0;
        @(negedge clk); #1;

        // Small row, no stall.
        log_q.delete();
        send_cmd(2, 4, 3, 3, 'hABC);
        n = acc_cyc;
        wait_dones(100);
        chk(log_q.size() == 3, "t1_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk(log_q[0].addr == 1922, "t1_addr0", log_q[0].addr, 1922);
            chk(log_q[1].addr == 1923, "t1_addr1", log_q[1].addr, 1923);
            chk(log_q[2].addr == 1924, "t1_addr2", log_q[2].addr, 1924);
            chk(log_q[0].data == 'h0ABC, "t1_data", log_q[0].data, 'h0ABC);
            chk(log_q[0].cyc == n + 2, "t1_first_cyc", log_q[0].cyc - n, 2);
            chk(log_q[2].cyc == log_q[0].cyc + 2, "t1_consecutive", log_q[2].cyc - log_q[0].cyc, 2);
            chk(done_cyc == log_q[2].cyc + 1, "t1_done_cyc", done_cyc - log_q[2].cyc, 1);
        end

        // Same row, second write stalled for three cycles.
        log_q.delete();
        watch_addr = 1923;
        watch_cnt  = 0;
        send_cmd(2, 4, 3, 3, 'hABC);
        n = 0;
        while (!src_avn_write && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        wr_force = 1'b1;
        repeat (4) @(posedge clk);
        wr_force = 1'b0;
        wait_dones(100);
        chk(watch_cnt == 4, "t2_hold_cycles", watch_cnt, 4);
        chk(log_q.size() == 3, "t2_count", log_q.size(), 3);
        watch_addr = -1;

        // Right edge clipping.
        log_q.delete();
        send_cmd(630, 700, 100, 105, 'h123);
        wait_dones(300);
        chk(log_q.size() == 60, "t3_count", log_q.size(), 60);
        if (log_q.size() == 60) begin
            chk(log_q[0].addr == 64630, "t3_first", log_q[0].addr, 64630);
            chk(log_q[59].addr == 67839, "t3_last", log_q[59].addr, 67839);
        end

        // Empty rectangle.
        log_q.delete();
        send_cmd(10, 5, 0, 0, 'hFFF);
        n = acc_cyc;
        wait_dones(50);
        chk(log_q.size() == 0, "t4_no_writes", log_q.size(), 0);
        chk(done_cyc == n + 2, "t4_done_cyc", done_cyc - n, 2);
        chk(cmd_ready == 1'b0, "t4_ready_at_done", cmd_ready, 0);
        @(negedge clk); #1;
        chk(cmd_ready == 1'b1, "t4_ready_after", cmd_ready, 1);

        // Reset in the middle of a 20 pixel fill.
        log_q.delete();
        send_cmd(0, 19, 7, 7, 'h555);
        n = 0;
        while (log_q.size() < 5 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #2;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_done = done_cnt;
        @(negedge clk); #1;
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(log_q.size() == 5, "t5_written_before_reset", log_q.size(), 5);
        chk(busy == 1'b0, "t5_no_resume", busy, 0);
        log_q.delete();
        send_cmd(5, 8, 2, 3, 'h0F0);
        wait_dones(100);
        chk(log_q.size() == 8, "t5_refill_count", log_q.size(), 8);

        // Command pulsed while busy is dropped.
        log_q.delete();
        send_cmd(100, 109, 200, 201, 'h321);
        repeat (3) @(negedge clk);
        #1;
        chk(cmd_ready == 1'b0, "t6_ready_busy", cmd_ready, 0);
        cmd_x0 = H_W'(0); cmd_x1 = H_W'(3); cmd_y0 = V_W'(0); cmd_y1 = V_W'(0);
        cmd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_dones(200);
        repeat (5) @(negedge clk);
        #1;
        chk(log_q.size() == 20, "t6_count", log_q.size(), 20);

        // Random rectangles with random back-pressure.
        wr_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(625, 700) : $urandom_range(0, 700);
            y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 500) : $urandom_range(0, 500);
            x1 = x0 + $urandom_range(0, 14) - 2;
            y1 = y0 + $urandom_range(0, 10) - 2;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            send_cmd(x0, x1, y0, y1, $urandom_range(0, 4095));
            wait_dones(3000);
        end
        wr_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
